// File: rtl/seq_bit_serializer_if.sv
// Parallel-word valid/ready handshake feeding seq_bit_serializer.
// The master offers words; the slave (serializer) reports buffer space.
interface seq_bit_serializer_if #(
  parameter int WIDTH = 6
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_data_i;

  modport master (output in_valid_i, output in_data_i, input in_ready_o);
  modport slave  (input in_valid_i, input in_data_i, output in_ready_o);
endinterface

// File: rtl/seq_bit_serializer.sv
// MSB-first parallel-to-serial converter with a one-word pending buffer for gapless streaming.
// Optional macro SER_PARITY_EN appends an even-parity bit (^word) after each word's data bits.
module seq_bit_serializer #(
  parameter int   WIDTH    = 6,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 flush_i,
  seq_bit_serializer_if.slave  in_if,
  output logic                 data_o,
  output logic                 bit_valid_o,
  output logic                 word_start_o,
  output logic                 busy_o
);

`ifdef SER_PARITY_EN
  localparam int TOTAL = WIDTH + 1;
`else
  localparam int TOTAL = WIDTH;
`endif
  localparam int CW = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_d;
  logic [CW-1:0]    bit_cnt, cnt_d;
  logic [WIDTH-1:0] shift_reg, shift_d;
  logic [WIDTH-1:0] pend_word, pend_word_d;
  logic             pend_valid, pend_valid_d;
  logic             data_d, bit_valid_d, word_start_d;
  logic             load;
`ifdef SER_PARITY_EN
  logic             par_bit, par_d;
`endif

  assign in_if.in_ready_o = !pend_valid;
  assign busy_o           = (state == SHIFT) || pend_valid;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d      = state;
    cnt_d        = bit_cnt;
    shift_d      = shift_reg;
    pend_word_d  = pend_word;
    pend_valid_d = pend_valid;
    data_d       = data_o;
    bit_valid_d  = 1'b0;
    word_start_d = 1'b0;
    load         = 1'b0;
`ifdef SER_PARITY_EN
    par_d        = par_bit;
`endif

    unique case (state)
      IDLE: begin
        data_d = IDLE_BIT;
        cnt_d  = '0;
        if (en_i && pend_valid) load = 1'b1;
      end
      SHIFT: begin
        if (en_i) begin
          // shift_reg[WIDTH-1] was emitted on the previous enabled edge; send the next one down.
          if (bit_cnt < WIDTH_C) begin
            data_d      = shift_reg[WIDTH-2];
            shift_d     = shift_reg << 1;
            bit_valid_d = 1'b1;
            cnt_d       = bit_cnt + CW'(1);
          end
`ifdef SER_PARITY_EN
          else if (bit_cnt == WIDTH_C) begin
            data_d      = par_bit;
            bit_valid_d = 1'b1;
            cnt_d       = bit_cnt + CW'(1);
          end
`endif
          else if (pend_valid) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            data_d  = IDLE_BIT;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d      = pend_word;
      data_d       = pend_word[WIDTH-1];
      bit_valid_d  = 1'b1;
      word_start_d = 1'b1;
      cnt_d        = CW'(1);
      pend_valid_d = 1'b0;
      state_d      = SHIFT;
`ifdef SER_PARITY_EN
      par_d        = ^pend_word;
`endif
    end

    // Acceptance looks at the registered pend_valid, so a word offered on the edge that drains the buffer is not taken.
    if (in_if.in_valid_i && !pend_valid) begin
      pend_word_d  = in_if.in_data_i;
      pend_valid_d = 1'b1;
    end

    if (flush_i) begin
      state_d      = IDLE;
      cnt_d        = '0;
      pend_valid_d = 1'b0;
      data_d       = IDLE_BIT;
      bit_valid_d  = 1'b0;
      word_start_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      // NOTE: datapath registers are reset too; it costs little here and keeps reset-to-output behaviour fully defined.
      shift_reg    <= '0;
      pend_word    <= '0;
      pend_valid   <= 1'b0;
      data_o       <= IDLE_BIT;
      bit_valid_o  <= 1'b0;
      word_start_o <= 1'b0;
`ifdef SER_PARITY_EN
      par_bit      <= 1'b0;
`endif
    end else begin
      state        <= state_d;
      bit_cnt      <= cnt_d;
      shift_reg    <= shift_d;
      pend_word    <= pend_word_d;
      pend_valid   <= pend_valid_d;
      data_o       <= data_d;
      bit_valid_o  <= bit_valid_d;
      word_start_o <= word_start_d;
`ifdef SER_PARITY_EN
      par_bit      <= par_d;
`endif
    end
  end

endmodule
